piezo_sequencer: RTL and testbench

Queued tone generator for a piezo transducer on the XUM memory-mapped I/O bus. Software writes (half-period, duration) note words into a DEPTH-entry FIFO; the block plays them back-to-back without CPU involvement and pulses Done when the queue drains. It is the parametrised successor to the single-tone piezo driver, adding timed notes, rests, queueing, flush and status.

---
 rtl/piezo_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_piezo_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piezo_sequencer.sv
// piezo_sequencer: queued tone generator for a piezo transducer.
// Host writes (half-period, duration) note words into a DEPTH-entry FIFO;
// notes play back-to-back and Done pulses when the queue drains.
// Optional build macro PIEZO_LOOP_EN adds a Loop input that recirculates
// popped notes to the FIFO tail so the melody repeats.
module piezo_sequencer #(
  parameter int unsigned PERIOD_WIDTH = 24,
  parameter int unsigned DUR_WIDTH    = 16,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned TICK_DIV     = 100000
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [PERIOD_WIDTH+DUR_WIDTH-1:0] data,
  input  logic                              Write,
  output logic                              Ack,
  input  logic                              Flush,
`ifdef PIEZO_LOOP_EN
  input  logic                              Loop,
`endif
  output logic                              Piezo,
  output logic                              Empty,
  output logic                              Full,
  output logic [$clog2(DEPTH):0]            Count,
  output logic                              Busy,
  output logic                              Overflow,
  output logic                              Done
);

  localparam int unsigned WORD_W = PERIOD_WIDTH + DUR_WIDTH;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WORD_W-1:0]       mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [WORD_W-1:0]       note_q;
  logic [PERIOD_WIDTH-1:0] h_q, tone_q;
  logic [DUR_WIDTH-1:0]    d_q, tick_q;
  logic [PRE_W-1:0]        pre_q;

  logic                    pop, drain, recirc, accept, push, wr_en, ovf_set;
  logic                    pre_last, last_cycle, tone_wrap;
  logic [WORD_W-1:0]       wr_data;
  logic [CNT_W-1:0]        count_d;
  logic [PERIOD_WIDTH-1:0] note_h;
  logic [DUR_WIDTH-1:0]    note_d;

  assign note_h     = note_q[PERIOD_WIDTH-1:0];
  assign note_d     = note_q[WORD_W-1:PERIOD_WIDTH];
  assign pre_last   = (pre_q == PRE_W'(TICK_DIV - 1));
  assign last_cycle = (state_q == S_PLAY) && pre_last && (tick_q == d_q - DUR_WIDTH'(1));
  assign tone_wrap  = (h_q != '0) && (tone_q == h_q - PERIOD_WIDTH'(1));

`ifdef PIEZO_LOOP_EN
  assign recirc = Loop & pop;
`else
  assign recirc = 1'b0;
`endif

  // Host accept is blocked while the FIFO write port carries a recirculated note
  assign accept  = Write & ~Ack & ~recirc;
  assign push    = accept & ~Full & ~Flush;
  assign ovf_set = accept & Full;
  assign wr_en   = push | recirc;
  assign wr_data = recirc ? mem[rd_ptr] : data;
  assign count_d = Count + CNT_W'(wr_en) - CNT_W'(pop);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state, pop and drain decisions; Flush overrides everything
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    drain   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!Empty) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (note_d == '0) begin
          if (!Empty) begin
            pop     = 1'b1;
            state_d = S_LOAD;
          end else begin
            drain   = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (last_cycle) begin
          if (!Empty) begin
            pop     = 1'b1;
            state_d = S_LOAD;
          end else begin
            drain   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (Flush) begin
      state_d = S_IDLE;
      pop     = 1'b0;
      drain   = 1'b0;
    end
  end

  // Bus acknowledge: rises on accept, held while Write stays high
  always_ff @(posedge clock) begin
    if (reset) Ack <= 1'b0;
    else       Ack <= Write & (Ack | accept);
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, occupancy and status flags
  always_ff @(posedge clock) begin
    if (reset || Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
      Empty  <= 1'b1;
      Full   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      Count <= count_d;
      Empty <= (count_d == '0);
      Full  <= (count_d == CNT_W'(DEPTH));
    end
  end

  // Popped note word, consumed by LOAD
  always_ff @(posedge clock) begin
    if (reset)    note_q <= '0;
    else if (pop) note_q <= mem[rd_ptr];
  end

  // Note parameters and tone/prescaler/tick counters
  always_ff @(posedge clock) begin
    if (reset) begin
      h_q    <= '0;
      d_q    <= '0;
      tone_q <= '0;
      pre_q  <= '0;
      tick_q <= '0;
    end else if (state_q == S_LOAD) begin
      h_q    <= note_h;
      d_q    <= note_d;
      tone_q <= '0;
      pre_q  <= '0;
      tick_q <= '0;
    end else if (state_q == S_PLAY) begin
      if (tone_wrap)       tone_q <= '0;
      else if (h_q != '0) tone_q <= tone_q + PERIOD_WIDTH'(1);
      if (pre_last) begin
        pre_q  <= '0;
        tick_q <= tick_q + DUR_WIDTH'(1);
      end else begin
        pre_q  <= pre_q + PRE_W'(1);
      end
    end
  end

  // Transducer drive: toggles on tone wrap while a note keeps playing, else low
  always_ff @(posedge clock) begin
    if (reset || Flush)                      Piezo <= 1'b0;
    else if (state_q == S_PLAY && !last_cycle) begin
      if (tone_wrap) Piezo <= ~Piezo;
    end else                                  Piezo <= 1'b0;
  end

  // Sticky overflow flag, cleared by Flush
  always_ff @(posedge clock) begin
    if (reset || Flush) Overflow <= 1'b0;
    else if (ovf_set)   Overflow <= 1'b1;
  end

  // Done pulse and Busy status
  always_ff @(posedge clock) begin
    if (reset) begin
      Done <= 1'b0;
      Busy <= 1'b0;
    end else begin
      Done <= drain;
      Busy <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_piezo_sequencer.sv
// Testbench for piezo_sequencer: lockstep comparison against a queue-based
// behavioural model plus directed checks of timing, overflow, flush and skip.
module tb_piezo_sequencer;
  localparam int unsigned PW    = 24;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TD    = 4;
  localparam int unsigned WW    = PW + DW;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned VW    = CW + 7;

  logic          clock = 1'b0;
  logic          reset;
  logic [WW-1:0] data;
  logic          Write, Flush, loop_r;
  logic          Ack, Piezo, Empty, Full, Busy, Overflow, Done;
  logic [CW-1:0] Count;
  logic [VW-1:0] dutv;

  always #5 clock = ~clock;

  piezo_sequencer #(.PERIOD_WIDTH(PW), .DUR_WIDTH(DW), .DEPTH(DEPTH), .TICK_DIV(TD)) dut (
    .clock(clock), .reset(reset), .data(data), .Write(Write), .Ack(Ack), .Flush(Flush),
`ifdef PIEZO_LOOP_EN
    .Loop(loop_r),
`endif
    .Piezo(Piezo), .Empty(Empty), .Full(Full), .Count(Count), .Busy(Busy),
    .Overflow(Overflow), .Done(Done)
  );

  assign dutv = {Ack, Piezo, Empty, Full, Count, Busy, Overflow, Done};

  // Behavioural model: note queue, phase (0 idle, 1 load, 2 play), play-cycle index
  logic [WW-1:0] q[$];
  logic [WW-1:0] hq[$];
  int            m_phase, m_k, m_h, m_d;
  logic [WW-1:0] m_pend;
  logic          m_ack, m_piezo, m_ovf, m_done, m_busy;
  int            cyc_n = 0;

  int total, bad;
  int ack_rises, done_cnt, done_cyc, first_rise, pz_rises, raise_cyc;
  logic ack_prev, pz_prev;

  function automatic logic [WW-1:0] note(input int h, input int d);
    return {DW'(d), PW'(h)};
  endfunction

  function automatic logic [VW-1:0] expv();
    return {m_ack, m_piezo, q.size() == 0, q.size() == DEPTH, CW'(q.size()), m_busy, m_ovf, m_done};
  endfunction

  always @(posedge clock) begin
    int sz, nph;
    bit pop, drain, acc, rc, fullb;
    logic [WW-1:0] w;
    cyc_n++;
    if (reset) begin
      q.delete();
      m_phase = 0; m_k = 0; m_h = 0; m_d = 0; m_pend = '0;
      m_ack = 0; m_piezo = 0; m_ovf = 0; m_done = 0; m_busy = 0;
    end else begin
      sz = q.size(); fullb = (sz == DEPTH); pop = 0; drain = 0; nph = m_phase;
      if (!Flush) begin
        case (m_phase)
          0: if (sz > 0) begin pop = 1; nph = 1; end
          1: begin
            if (m_pend[WW-1:PW] == '0) begin
              if (sz > 0) pop = 1;
              else begin nph = 0; drain = 1; end
            end else begin
              nph = 2; m_h = int'(m_pend[PW-1:0]); m_d = int'(m_pend[WW-1:PW]); m_k = 0;
            end
          end
          default: begin
            if (m_k == m_d * TD - 1) begin
              if (sz > 0) begin pop = 1; nph = 1; end
              else begin nph = 0; drain = 1; end
            end else m_k++;
          end
        endcase
      end
      rc  = loop_r && pop;
      acc = Write && !m_ack && !rc;
      if (Flush) begin
        q.delete(); m_ovf = 0; nph = 0;
      end else begin
        if (pop) begin
          w = q.pop_front(); m_pend = w;
          if (rc) q.push_back(w);
        end
        if (acc) begin
          if (fullb) m_ovf = 1;
          else q.push_back(data);
        end
      end
      m_piezo = (!Flush && nph == 2 && m_h != 0) ? ((m_k / m_h) % 2 == 1) : 1'b0;
      m_ack   = Write && (m_ack || acc);
      m_done  = drain;
      m_phase = nph;
      m_busy  = (nph != 0);
    end
  end

  // Advance to the next falling edge and record DUT event statistics
  task automatic cyc();
    @(negedge clock);
    if (Ack && !ack_prev) ack_rises++;
    ack_prev = Ack;
    if (Done) begin done_cnt++; done_cyc = cyc_n; end
    if (Piezo && !pz_prev) begin
      pz_rises++;
      if (first_rise < 0) first_rise = cyc_n;
    end
    pz_prev = Piezo;
  endtask

  // Bus master: present queued words, hold Write until Ack
  task automatic host_step();
    if (Write && m_ack) Write = 1'b0;
    else if (!Write && !m_ack && hq.size() > 0) begin
      data = hq.pop_front();
      Write = 1'b1;
      if (raise_cyc < 0) raise_cyc = cyc_n;
    end
  endtask

  task automatic clear_stats();
    ack_rises = 0; done_cnt = 0; done_cyc = -1; first_rise = -1; pz_rises = 0; raise_cyc = -1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] rv;
    rv = '0; rv[VW-3] = 1'b1;
    reset = 1'b1; Write = 1'b1; data = '1;
    repeat (3) @(negedge clock);
    total++; if (dutv !== rv) begin bad++; $display("FAIL reset_values got=%h want=%h", dutv, rv); end
    reset = 1'b0; Write = 1'b0; data = '0;
    cyc(); total++; if (dutv !== rv) begin bad++; $display("FAIL reset_idle got=%h want=%h", dutv, rv); end
  endtask

  task automatic test_single_note();
    clear_stats();
    hq.push_back(note(3, 2));
    repeat (20) begin
      cyc(); total++;
      if (dutv !== expv()) begin bad++; $display("FAIL lockstep_single cyc=%0d got=%h want=%h", cyc_n, dutv, expv()); end
      host_step();
    end
    total++; if (first_rise != raise_cyc + 6) begin bad++; $display("FAIL single_first_rise got=%0d want=%0d", first_rise, raise_cyc + 6); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", done_cnt); end
    total++; if (done_cyc != raise_cyc + 11) begin bad++; $display("FAIL single_done_cycle got=%0d want=%0d", done_cyc, raise_cyc + 11); end
    total++; if (Empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%b want=1", Empty); end
  endtask

  task automatic test_rest();
    clear_stats();
    hq.push_back(note(2, 1)); hq.push_back(note(0, 1)); hq.push_back(note(5, 1));
    repeat (35) begin
      cyc(); total++;
      if (dutv !== expv()) begin bad++; $display("FAIL lockstep_rest cyc=%0d got=%h want=%h", cyc_n, dutv, expv()); end
      host_step();
    end
    total++; if (pz_rises != 1) begin bad++; $display("FAIL rest_rises got=%0d want=1", pz_rises); end
    total++; if (done_cyc != raise_cyc + 17) begin bad++; $display("FAIL rest_done_cycle got=%0d want=%0d", done_cyc, raise_cyc + 17); end
  endtask

  task automatic test_skip();
    clear_stats();
    hq.push_back(note(4, 1)); hq.push_back(note(9, 0)); hq.push_back(note(1, 1));
    repeat (30) begin
      cyc(); total++;
      if (dutv !== expv()) begin bad++; $display("FAIL lockstep_skip cyc=%0d got=%h want=%h", cyc_n, dutv, expv()); end
      host_step();
    end
    total++; if (pz_rises != 2) begin bad++; $display("FAIL skip_rises got=%0d want=2", pz_rises); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL skip_done_count got=%0d want=1", done_cnt); end
    total++; if (done_cyc != raise_cyc + 13) begin bad++; $display("FAIL skip_done_cycle got=%0d want=%0d", done_cyc, raise_cyc + 13); end
  endtask

  task automatic test_overflow();
    clear_stats();
    hq.push_back(note(7, 100));
    for (int i = 0; i < DEPTH + 1; i++) hq.push_back(note(1, 1));
    for (int i = 0; i < 120 && (hq.size() > 0 || Write || m_ack); i++) begin
      cyc(); total++;
      if (dutv !== expv()) begin bad++; $display("FAIL lockstep_ovf cyc=%0d got=%h want=%h", cyc_n, dutv, expv()); end
      host_step();
    end
    total++; if (hq.size() != 0 || Write) begin bad++; $display("FAIL ovf_timeout pending=%0d want=0", hq.size()); end
    total++; if (Full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b want=1", Full); end
    total++; if (Count !== CW'(DEPTH)) begin bad++; $display("FAIL ovf_count got=%0d want=%0d", Count, DEPTH); end
    total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", Overflow); end
    total++; if (ack_rises != DEPTH + 2) begin bad++; $display("FAIL ovf_acks got=%0d want=%0d", ack_rises, DEPTH + 2); end
  endtask

  task automatic test_flush();
    clear_stats();
    for (int i = 0; i < 40 && !Piezo; i++) begin
      cyc(); total++;
      if (dutv !== expv()) begin bad++; $display("FAIL lockstep_flush_wait cyc=%0d got=%h want=%h", cyc_n, dutv, expv()); end
    end
    total++; if (Piezo !== 1'b1) begin bad++; $display("FAIL flush_setup piezo=%b want=1", Piezo); end
    Write = 1'b1; data = note(2, 2); Flush = 1'b1;
    cyc(); Flush = 1'b0; total++;
    if (dutv !== expv()) begin bad++; $display("FAIL lockstep_flush cyc=%0d got=%h want=%h", cyc_n, dutv, expv()); end
    total++; if (Piezo !== 1'b0) begin bad++; $display("FAIL flush_piezo got=%b want=0", Piezo); end
    total++; if (Count !== '0) begin bad++; $display("FAIL flush_count got=%0d want=0", Count); end
    total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL flush_ovf got=%b want=0", Overflow); end
    total++; if (Ack !== 1'b1) begin bad++; $display("FAIL flush_ack got=%b want=1", Ack); end
    host_step();
    repeat (12) begin
      cyc(); total++;
      if (dutv !== expv()) begin bad++; $display("FAIL lockstep_flush_after cyc=%0d got=%h want=%h", cyc_n, dutv, expv()); end
      host_step();
    end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL flush_done got=%0d want=0", done_cnt); end
    total++; if (Empty !== 1'b1 || Busy !== 1'b0) begin bad++; $display("FAIL flush_discard empty=%b busy=%b want 1 0", Empty, Busy); end
  endtask

`ifdef PIEZO_LOOP_EN
  task automatic test_loop();
    bit found;
    clear_stats();
    loop_r = 1'b1;
    hq.push_back(note(2, 1)); hq.push_back(note(3, 1));
    repeat (60) begin
      cyc(); total++;
      if (dutv !== expv()) begin bad++; $display("FAIL lockstep_loop cyc=%0d got=%h want=%h", cyc_n, dutv, expv()); end
      host_step();
    end
    total++; if (Count !== CW'(2)) begin bad++; $display("FAIL loop_count got=%0d want=2", Count); end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL loop_done got=%0d want=0", done_cnt); end
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(); total++;
      if (dutv !== expv()) begin bad++; $display("FAIL lockstep_loop_wait cyc=%0d got=%h want=%h", cyc_n, dutv, expv()); end
      if (m_phase == 2 && m_k == m_d * TD - 1) found = 1;
    end
    total++; if (!found) begin bad++; $display("FAIL loop_align found=0 want=1"); end
    Write = 1'b1; data = note(1, 2);
    cyc(); total++;
    if (Ack !== 1'b0) begin bad++; $display("FAIL loop_defer ack=%b want=0", Ack); end
    cyc(); total++;
    if (Ack !== 1'b1) begin bad++; $display("FAIL loop_ack_late ack=%b want=1", Ack); end
    host_step();
    repeat (60) begin
      cyc(); total++;
      if (dutv !== expv()) begin bad++; $display("FAIL lockstep_loop3 cyc=%0d got=%h want=%h", cyc_n, dutv, expv()); end
      host_step();
    end
    total++; if (Count !== CW'(3)) begin bad++; $display("FAIL loop_count3 got=%0d want=3", Count); end
    loop_r = 1'b0;
    repeat (60) begin
      cyc(); total++;
      if (dutv !== expv()) begin bad++; $display("FAIL lockstep_unloop cyc=%0d got=%h want=%h", cyc_n, dutv, expv()); end
      host_step();
    end
    total++; if (done_cnt != 1 || Empty !== 1'b1) begin bad++; $display("FAIL unloop_drain done=%0d empty=%b want 1 1", done_cnt, Empty); end
  endtask
`endif

  task automatic test_random();
    clear_stats();
    for (int i = 0; i < 1500; i++) begin
      cyc(); total++;
      if (dutv !== expv()) begin bad++; $display("FAIL lockstep_random cyc=%0d got=%h want=%h", cyc_n, dutv, expv()); end
      Flush = 1'b0;
      if (hq.size() < 2 && $urandom_range(0, 3) == 0)
        hq.push_back(note(int'($urandom_range(0, 4)), int'($urandom_range(1, 3))));
      if ($urandom_range(0, 99) == 0) Flush = 1'b1;
`ifdef PIEZO_LOOP_EN
      if ($urandom_range(0, 63) == 0) loop_r = ~loop_r;
`endif
      host_step();
    end
    Flush = 1'b0; loop_r = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; ack_prev = 1'b0; pz_prev = 1'b0;
    reset = 1'b1; Write = 1'b0; Flush = 1'b0; data = '0; loop_r = 1'b0;
    clear_stats();
    test_reset();
    test_single_note();
    test_rest();
    test_skip();
    test_overflow();
    test_flush();
`ifdef PIEZO_LOOP_EN
    test_loop();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
